// File: rtl/uart_pkg.sv
// Shared definitions for the fast UART receive/transmit DMA blocks.
package uart_pkg;

  localparam int UART_ADDR_W        = 16;
  localparam int UART_RX_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for the receive DMA path. Registered occupancy count,
// flush input, and a push into a full FIFO is accepted when a pop happens
// in the same cycle. DEPTH must be a power of two so pointers wrap freely.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and count update; flush empties the FIFO outright.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_rx_dma_writer.sv
// Receive DMA writer: buffers UART receiver bytes and writes them through an
// Avalon-MM master into the window [start_addr, stop_addr].
// Optional build macro UART_RX_PACK_EN packs four bytes (little-endian) per
// word; a trailing partial word is flushed zero-padded when enable drops.
module uart_rx_dma_writer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = UART_RX_FIFO_DEPTH,
  parameter int ADDR_W     = UART_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_char,
  input  logic              enable,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] stop_addr,
  output logic              work,
  output logic              overflow,
  output logic              avm_write,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  output logic [ADDR_W-1:0] avm_address,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata
);

`ifdef UART_RX_PACK_EN
  localparam int ENTRY_W = 32;
`else
  localparam int ENTRY_W = 8;
`endif

  rx_state_e         state_q, state_d;
  logic              enable_q, enable_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              write_q, write_d;
  logic              overflow_q, overflow_d;
  logic              fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  logic              enable_rise, wr_done, win_full, pend, part_pend;
  logic              unused_inputs;
`ifdef UART_RX_PACK_EN
  logic [23:0]       pack_q, pack_d;
  logic [1:0]        pack_cnt_q, pack_cnt_d;
  logic              pend_q, pend_d;
`endif

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign work          = (state_q != IDLE);
  assign overflow      = overflow_q;
  assign avm_write     = write_q;
  assign avm_read      = 1'b0;
  assign avm_address   = addr_q;
  assign avm_writedata = data_q;
  assign unused_inputs = ^{avm_readdatavalid, avm_readdata};

  // Session FSM, byte intake, writer load and write completion.
  always_comb begin
    state_d    = state_q;
    enable_d   = enable;
    cur_addr_d = cur_addr_q;
    lim_d      = lim_q;
    addr_d     = addr_q;
    data_d     = data_q;
    write_d    = write_q;
    overflow_d = overflow_q;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_wdata = '0;
    win_full   = 1'b0;
`ifdef UART_RX_PACK_EN
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    pend_d     = pend_q;
    pend       = (pack_cnt_q != 2'd0);
    part_pend  = pend_q;
`else
    pend       = 1'b0;
    part_pend  = 1'b0;
`endif
    enable_rise = enable && !enable_q;
    wr_done     = write_q && !avm_waitrequest;

    case (state_q)
      IDLE: begin
        if (enable_rise && (start_addr <= stop_addr)) begin
          state_d    = RUN;
          cur_addr_d = start_addr;
          lim_d      = stop_addr;
          overflow_d = 1'b0;
          fifo_flush = 1'b1;
`ifdef UART_RX_PACK_EN
          pack_d     = '0;
          pack_cnt_d = '0;
          pend_d     = 1'b0;
`endif
        end
      end

      RUN: begin
        if (wr_done) begin
          write_d = 1'b0;
          if (cur_addr_q == lim_q) begin
            state_d  = IDLE;
            win_full = 1'b1;
          end else begin
            cur_addr_d = cur_addr_q + 1'b1;
          end
        end
        if (!win_full) begin
          if (!enable) begin
            // Queued data is discarded; only the in-flight write (and a
            // partial packed word, when packing) still goes out.
            fifo_flush = 1'b1;
`ifdef UART_RX_PACK_EN
            pend_d     = pend;
`endif
            state_d = ((write_q && !wr_done) || pend) ? DRAIN : IDLE;
          end else begin
            if (!write_q && !fifo_empty) begin
              fifo_pop = 1'b1;
              write_d  = 1'b1;
              addr_d   = cur_addr_q;
`ifdef UART_RX_PACK_EN
              data_d   = fifo_rdata;
`else
              data_d   = {24'h0, fifo_rdata};
`endif
            end
            if (rx_rdy) begin
`ifdef UART_RX_PACK_EN
              if (pack_cnt_q == 2'd3) begin
                fifo_push  = 1'b1;
                fifo_wdata = {rx_char, pack_q};
                pack_d     = '0;
                pack_cnt_d = '0;
              end else begin
                case (pack_cnt_q)
                  2'd0:    pack_d[7:0]   = rx_char;
                  2'd1:    pack_d[15:8]  = rx_char;
                  default: pack_d[23:16] = rx_char;
                endcase
                pack_cnt_d = pack_cnt_q + 2'd1;
              end
`else
              fifo_push  = 1'b1;
              fifo_wdata = rx_char;
`endif
            end
            if (fifo_push && fifo_full && !fifo_pop) begin
              overflow_d = 1'b1;
            end
          end
        end
      end

      DRAIN: begin
        if (wr_done) begin
          write_d = 1'b0;
          if ((cur_addr_q == lim_q) || !part_pend) begin
            state_d = IDLE;
          end else begin
            cur_addr_d = cur_addr_q + 1'b1;
          end
        end else if (!write_q) begin
          if (part_pend) begin
`ifdef UART_RX_PACK_EN
            write_d = 1'b1;
            addr_d  = cur_addr_q;
            data_d  = {8'h0, pack_q};
            pend_d  = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, window and Avalon request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      enable_q   <= 1'b0;
      cur_addr_q <= '0;
      lim_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_RX_PACK_EN
      pack_q     <= '0;
      pack_cnt_q <= '0;
      pend_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      cur_addr_q <= cur_addr_d;
      lim_q      <= lim_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      write_q    <= write_d;
      overflow_q <= overflow_d;
`ifdef UART_RX_PACK_EN
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
      pend_q     <= pend_d;
`endif
    end
  end

endmodule

// File: doc/uart_rx_dma_writer.md
# uart_rx_dma_writer

Receive-side DMA stage of the fast UART. Consumes one-cycle character strobes from the UART receiver and buffers them in a small FIFO. Writes them through an Avalon-MM master into the memory window `[start_addr, stop_addr]` programmed by the control registers, and reports progress back to them. Its master port is one input of the UART Avalon connector/arbiter.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of two, ≥ 2.
- `ADDR_W`, default 16: Avalon address width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `rx_rdy`, in, 1: receiver strobe. Each high cycle delivers one byte.
- `rx_char`, in, 8: received byte, valid while `rx_rdy` is high.
- `enable`, in, 1: receive enable, level, from the control registers.
- `start_addr`, in, ADDR_W: first word address of the window.
- `stop_addr`, in, ADDR_W: last word address of the window (inclusive).
- `work`, out, 1: high while a session is active or a write is pending.
- `overflow`, out, 1: sticky flag, set when a byte is dropped on a full FIFO.
- `avm_write`, out, 1: Avalon write request.
- `avm_read`, out, 1: constant 0.
- `avm_waitrequest`, in, 1: Avalon stall.
- `avm_readdatavalid`, in, 1: unused.
- `avm_address`, out, ADDR_W: word address.
- `avm_writedata`, out, 32: write data.
- `avm_readdata`, in, 32: unused.

## Operation
- States:
  - IDLE: no session.
  - RUN: accepting bytes and writing.
  - DRAIN: `enable` has dropped; completing the in-flight write only.
- IDLE→RUN on a rising edge of `enable` (registered compare) when `start_addr ≤ stop_addr`.
  - On entry: `cur_addr` ← `start_addr`, `lim` ← `stop_addr`, `overflow` ← 0, FIFO flushed.
  - If `start_addr > stop_addr`, the block stays in IDLE and `work` stays 0.
- RUN, byte push: every cycle with `rx_rdy` = 1 pushes `rx_char`.
  - FIFO full with no pop in the same cycle: byte is dropped and `overflow` ← 1.
  - FIFO full with a pop in the same cycle: byte is accepted.
- RUN, writer: when `avm_write` = 0 and the FIFO is not empty, the writer pops one entry into a data register and asserts `avm_write` with `avm_address` = `cur_addr`.
  - `avm_write`, `avm_address` and `avm_writedata` stay stable while `avm_waitrequest` = 1.
  - The write completes in the first cycle with `avm_write` = 1 and `avm_waitrequest` = 0.
- On completion: if `cur_addr == lim` → IDLE (window full). Otherwise `cur_addr` ← `cur_addr` + 1. No wrap-around; the window ends at `lim`.
- In IDLE, bytes arriving after the window is full are ignored and `overflow` is not set.
- `enable` falls during RUN:
  - Stop pushing; discard the FIFO contents.
  - If a write is in flight → DRAIN, and go to IDLE when it completes. Otherwise → IDLE immediately.
- `enable` rising again during DRAIN is ignored; re-arm requires a new rising edge seen in IDLE.
- `work` = 1 in RUN and DRAIN, 0 in IDLE.
- Reset value of all outputs: 0 (`avm_address` = 0, `avm_writedata` = 0).
- Reset mid-transfer drops the request immediately.

## Timing
- Latency, idle bus: `rx_rdy` sampled high at edge N → `avm_write` high after edge N+1 (visible one cycle later).
- Back-to-back: with `avm_waitrequest` = 0 throughout, one write completes every 2 cycles (load cycle plus accept cycle).
- `work` falls the cycle after the completing edge of the last write.
- `overflow` sets on the edge where the byte is dropped.
- `avm_write` never deasserts while `avm_waitrequest` = 1.

## Configuration
- `UART_RX_PACK_EN` defined:
  - Bytes are packed little-endian, first byte in [7:0], four bytes per FIFO entry and per write.
  - When `enable` falls with 1–3 bytes pending, the partial word is written zero-padded before IDLE (via DRAIN).
  - Overflow is evaluated per completed word.
- `UART_RX_PACK_EN` undefined: one byte per write, `avm_writedata` = {24'h0, byte}.

## Structure
- Shared package `uart_pkg`: state enum (IDLE/RUN/DRAIN), `UART_ADDR_W` = 16, default FIFO depth constant.
- Sub-module `uart_rx_fifo`: synchronous FIFO, registered count, flush input, simultaneous push/pop when full.

## Test plan
- Window 0x0100..0x0102, `waitrequest` = 0, send 0x41, 0x42, 0x43 → writes of 0x41 @0x0100, 0x42 @0x0101, 0x43 @0x0102; `work` then falls; a fourth byte 0x44 produces no write.
- Hold `waitrequest` = 1 for 5 cycles on the first write → `avm_address` and `avm_writedata` stable, exactly one write accepted.
- `waitrequest` = 1 for 40 cycles, send 10 bytes with depth 8 → 8 (or 9 with pop overlap) written in order, `overflow` = 1.
- Drop `enable` while the write of byte 2 is stalled → that write completes, the 3 queued bytes are discarded, IDLE, `work` = 0.
- `start_addr` = 5, `stop_addr` = 4, rising `enable` → `work` stays 0, no writes.
- With `UART_RX_PACK_EN`: bytes 01 02 03 04 05, then `enable` falls → writes 0x04030201 and 0x00000005 at consecutive addresses.
